// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit
// Branch-condition evaluation and resolution stage. Evaluates the conditional
// branch types on WIDTH-bit operands with signed semantics, registers the
// resolved direction, compares it with the front-end prediction to raise a
// one-cycle flush, trains a 2-bit saturating branch history table (BHT) read
// by fetch, and keeps saturating taken / mispredict statistics.

module branch_resolve_unit #(
    parameter int WIDTH     = 32,
    parameter int IDX_BITS  = 6,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 stall,
    input  logic [31:0]          lookup_pc,
    output logic                 predict_taken,
    input  logic                 in_valid,
    input  logic [31:0]          in_pc,
    input  logic [WIDTH-1:0]     rs,
    input  logic [WIDTH-1:0]     rt,
    input  logic [2:0]           op,
    input  logic                 in_pred_taken,
    output logic                 out_valid,
    output logic                 out_taken,
    output logic                 out_mispredict,
    output logic                 flush,
    output logic [CNT_WIDTH-1:0] taken_count,
    output logic [CNT_WIDTH-1:0] mispredict_count
);

    localparam int ENTRIES = 1 << IDX_BITS;

    // Branch opcode encodings; 3'b000 and 3'b111 are "no branch".
    localparam logic [2:0] OP_BEQ  = 3'b001;
    localparam logic [2:0] OP_BNE  = 3'b010;
    localparam logic [2:0] OP_BGTZ = 3'b011;
    localparam logic [2:0] OP_BGEZ = 3'b100;
    localparam logic [2:0] OP_BLTZ = 3'b101;
    localparam logic [2:0] OP_BLEZ = 3'b110;

    // One step of a 2-bit saturating counter: up on taken, down on not-taken.
    function automatic logic [1:0] bht_step(input logic [1:0] cur, input logic up);
        logic [1:0] nxt;
        if (up) begin
            if (cur == 2'b11) nxt = 2'b11;
            else              nxt = cur + 2'b01;
        end else begin
            if (cur == 2'b00) nxt = 2'b00;
            else              nxt = cur - 2'b01;
        end
        return nxt;
    endfunction

    // Statistics counter increment that sticks at all-ones.
    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] cnt,
                                                     input logic en);
        logic [CNT_WIDTH-1:0] nxt;
        if (en && (cnt != {CNT_WIDTH{1'b1}})) nxt = cnt + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        else                                  nxt = cnt;
        return nxt;
    endfunction

    logic [1:0]          bht_r [ENTRIES];
    logic [IDX_BITS-1:0] lookup_idx_s;
    logic [IDX_BITS-1:0] update_idx_s;
    logic                sign_s;
    logic                zero_s;
    logic                eq_s;
    logic                cond_s;
    logic                is_branch_s;
    logic                accept_s;
    logic                mispredict_s;
    logic                unused_pc_bits_s;

    assign lookup_idx_s = lookup_pc[IDX_BITS+1:2];
    assign update_idx_s = in_pc[IDX_BITS+1:2];

    // PC bits outside the table index carry no information for this block.
    assign unused_pc_bits_s = ^{lookup_pc[31:IDX_BITS+2], lookup_pc[1:0],
                                in_pc[31:IDX_BITS+2], in_pc[1:0]};

    // Signed comparisons against zero reduce to sign bit and zero detect.
    assign sign_s = rs[WIDTH-1];
    assign zero_s = (rs == {WIDTH{1'b0}});
    assign eq_s   = (rs == rt);

    // Decode the opcode and evaluate the branch condition.
    always_comb begin
        cond_s      = 1'b0;
        is_branch_s = 1'b0;
        case (op)
            OP_BEQ:  begin cond_s = eq_s;              is_branch_s = 1'b1; end
            OP_BNE:  begin cond_s = ~eq_s;             is_branch_s = 1'b1; end
            OP_BGTZ: begin cond_s = ~sign_s & ~zero_s; is_branch_s = 1'b1; end
            OP_BGEZ: begin cond_s = ~sign_s;           is_branch_s = 1'b1; end
            OP_BLTZ: begin cond_s = sign_s;            is_branch_s = 1'b1; end
            OP_BLEZ: begin cond_s = sign_s | zero_s;   is_branch_s = 1'b1; end
            default: begin cond_s = 1'b0;              is_branch_s = 1'b0; end
        endcase
    end

    assign accept_s     = in_valid & ~stall & is_branch_s;
    assign mispredict_s = cond_s ^ in_pred_taken;

    // Fetch reads the table state as of the start of the cycle (read-before-write).
    assign predict_taken = bht_r[lookup_idx_s][1];

    // Resolution outputs: load on accept, clear on idle, hold under stall.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid      <= 1'b0;
            out_taken      <= 1'b0;
            out_mispredict <= 1'b0;
            flush          <= 1'b0;
        end else if (stall) begin
            out_valid      <= out_valid;
            out_taken      <= out_taken;
            out_mispredict <= out_mispredict;
            flush          <= flush;
        end else if (accept_s) begin
            out_valid      <= 1'b1;
            out_taken      <= cond_s;
            out_mispredict <= mispredict_s;
            flush          <= mispredict_s;
        end else begin
            out_valid      <= 1'b0;
            out_taken      <= 1'b0;
            out_mispredict <= 1'b0;
            flush          <= 1'b0;
        end
    end

    // BHT training: every entry starts weakly not-taken, one step per accept.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                bht_r[i] <= 2'b01;
            end
        end else if (accept_s) begin
            bht_r[update_idx_s] <= bht_step(bht_r[update_idx_s], cond_s);
        end else begin
            bht_r[update_idx_s] <= bht_r[update_idx_s];
        end
    end

    // Saturating statistics counters, advanced only by accepted resolves.
    always_ff @(posedge clk) begin
        if (reset) begin
            taken_count      <= {CNT_WIDTH{1'b0}};
            mispredict_count <= {CNT_WIDTH{1'b0}};
        end else if (accept_s) begin
            taken_count      <= sat_inc(taken_count, cond_s);
            mispredict_count <= sat_inc(mispredict_count, mispredict_s);
        end else begin
            taken_count      <= taken_count;
            mispredict_count <= mispredict_count;
        end
    end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed testbench for branch_resolve_unit. A default-parameter instance
// and a CNT_WIDTH=2 instance share all inputs; the narrow one exercises
// counter saturation.

module tb_branch_resolve_unit;

    logic        clk;
    logic        reset;
    logic        stall;
    logic [31:0] lookup_pc;
    logic        in_valid;
    logic [31:0] in_pc;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [2:0]  op;
    logic        in_pred_taken;

    logic        predict_taken, out_valid, out_taken, out_mispredict, flush;
    logic [15:0] taken_count, mispredict_count;

    logic        s_predict_taken, s_out_valid, s_out_taken, s_out_mispredict, s_flush;
    logic [1:0]  s_taken_count, s_mispredict_count;

    int total;
    int bad;

    branch_resolve_unit #(.WIDTH(32), .IDX_BITS(6), .CNT_WIDTH(16)) u_dut (
        .clk(clk), .reset(reset), .stall(stall), .lookup_pc(lookup_pc),
        .predict_taken(predict_taken), .in_valid(in_valid), .in_pc(in_pc),
        .rs(rs), .rt(rt), .op(op), .in_pred_taken(in_pred_taken),
        .out_valid(out_valid), .out_taken(out_taken),
        .out_mispredict(out_mispredict), .flush(flush),
        .taken_count(taken_count), .mispredict_count(mispredict_count)
    );

    branch_resolve_unit #(.WIDTH(32), .IDX_BITS(6), .CNT_WIDTH(2)) u_small (
        .clk(clk), .reset(reset), .stall(stall), .lookup_pc(lookup_pc),
        .predict_taken(s_predict_taken), .in_valid(in_valid), .in_pc(in_pc),
        .rs(rs), .rt(rt), .op(op), .in_pred_taken(in_pred_taken),
        .out_valid(s_out_valid), .out_taken(s_out_taken),
        .out_mispredict(s_out_mispredict), .flush(s_flush),
        .taken_count(s_taken_count), .mispredict_count(s_mispredict_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [2:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic p, input logic [31:0] pc);
        in_valid      = v;
        op            = o;
        rs            = a;
        rt            = b;
        in_pred_taken = p;
        in_pc         = pc;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        stall = 1'b0;
        drive(1'b0, 3'b000, 32'h0, 32'h0, 1'b0, 32'h0);
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        lookup_pc = 32'h0000_0040;
        #1;
        total++; if (predict_taken !== 1'b0) begin bad++; $display("FAIL reset_predict got=%0b exp=0", predict_taken); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b exp=0", out_valid); end
        total++; if (out_taken !== 1'b0 || out_mispredict !== 1'b0) begin bad++; $display("FAIL reset_taken_mis got=%0b%0b exp=00", out_taken, out_mispredict); end
        total++; if (flush !== 1'b0) begin bad++; $display("FAIL reset_flush got=%0b exp=0", flush); end
        total++; if (taken_count !== 16'd0 || mispredict_count !== 16'd0) begin bad++; $display("FAIL reset_counts got=%0d/%0d exp=0/0", taken_count, mispredict_count); end
    endtask

    task automatic test_signed_bgez();
        do_reset();
        lookup_pc = 32'h0000_0200;
        drive(1'b1, 3'b100, 32'h8000_0000, 32'h0, 1'b1, 32'h0000_0200);
        tick();
        drive(1'b0, 3'b000, 32'h0, 32'h0, 1'b0, 32'h0);
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL bgez_valid got=%0b exp=1", out_valid); end
        total++; if (out_taken !== 1'b0) begin bad++; $display("FAIL bgez_taken got=%0b exp=0", out_taken); end
        total++; if (out_mispredict !== 1'b1) begin bad++; $display("FAIL bgez_mis got=%0b exp=1", out_mispredict); end
        total++; if (flush !== 1'b1) begin bad++; $display("FAIL bgez_flush got=%0b exp=1", flush); end
        total++; if (mispredict_count !== 16'd1 || taken_count !== 16'd0) begin bad++; $display("FAIL bgez_counts got=%0d/%0d exp=0/1", taken_count, mispredict_count); end
        tick();
        total++; if (out_valid !== 1'b0 || flush !== 1'b0) begin bad++; $display("FAIL bgez_clear got=%0b%0b exp=00", out_valid, flush); end
    endtask

    task automatic test_conditions();
        // {op, rs, rt, expected condition}
        logic [2:0]  t_op  [10];
        logic [31:0] t_rs  [10];
        logic [31:0] t_rt  [10];
        logic        t_exp [10];
        t_op[0] = 3'b011; t_rs[0] = 32'h8000_0000; t_rt[0] = 32'h0; t_exp[0] = 1'b0;
        t_op[1] = 3'b011; t_rs[1] = 32'h0000_0001; t_rt[1] = 32'h0; t_exp[1] = 1'b1;
        t_op[2] = 3'b011; t_rs[2] = 32'h0000_0000; t_rt[2] = 32'h0; t_exp[2] = 1'b0;
        t_op[3] = 3'b100; t_rs[3] = 32'h0000_0000; t_rt[3] = 32'h0; t_exp[3] = 1'b1;
        t_op[4] = 3'b101; t_rs[4] = 32'hFFFF_FFFF; t_rt[4] = 32'h0; t_exp[4] = 1'b1;
        t_op[5] = 3'b101; t_rs[5] = 32'h7FFF_FFFF; t_rt[5] = 32'h0; t_exp[5] = 1'b0;
        t_op[6] = 3'b110; t_rs[6] = 32'h0000_0001; t_rt[6] = 32'h0; t_exp[6] = 1'b0;
        t_op[7] = 3'b110; t_rs[7] = 32'h8000_0000; t_rt[7] = 32'h0; t_exp[7] = 1'b1;
        t_op[8] = 3'b001; t_rs[8] = 32'h1234_5678; t_rt[8] = 32'h1234_5679; t_exp[8] = 1'b0;
        t_op[9] = 3'b010; t_rs[9] = 32'h1234_5678; t_rt[9] = 32'h1234_5679; t_exp[9] = 1'b1;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, t_op[i], t_rs[i], t_rt[i], 1'b0, 32'h0000_0400);
            tick();
            total++;
            if (out_valid !== 1'b1 || out_taken !== t_exp[i] || out_mispredict !== t_exp[i]) begin
                bad++;
                $display("FAIL cond_%0d op=%0b got v/t/m=%0b%0b%0b exp=1%0b%0b", i, t_op[i],
                         out_valid, out_taken, out_mispredict, t_exp[i], t_exp[i]);
            end
        end
        drive(1'b0, 3'b000, 32'h0, 32'h0, 1'b0, 32'h0);
    endtask

    task automatic test_bht_train();
        logic exp_pred [5];
        exp_pred[0] = 1'b1; exp_pred[1] = 1'b1; exp_pred[2] = 1'b1; // 10, 11, 11
        exp_pred[3] = 1'b1; exp_pred[4] = 1'b0;                     // 10, 01
        do_reset();
        lookup_pc = 32'h0000_0100;
        #1;
        total++; if (predict_taken !== 1'b0) begin bad++; $display("FAIL bht_initial got=%0b exp=0", predict_taken); end
        for (int i = 0; i < 5; i++) begin
            if (i < 3) drive(1'b1, 3'b001, 32'd5, 32'd5, 1'b0, 32'h0000_0100);
            else       drive(1'b1, 3'b001, 32'd5, 32'd6, 1'b0, 32'h0000_0100);
            #1;
            total++; if (i > 0 && predict_taken !== exp_pred[i-1]) begin bad++; $display("FAIL bht_pre_%0d got=%0b exp=%0b", i, predict_taken, exp_pred[i-1]); end
            tick();
            total++; if (predict_taken !== exp_pred[i]) begin bad++; $display("FAIL bht_step_%0d got=%0b exp=%0b", i, predict_taken, exp_pred[i]); end
            if (i == 2) begin
                total++; if (taken_count !== 16'd3 || mispredict_count !== 16'd3) begin bad++; $display("FAIL bht_counts got=%0d/%0d exp=3/3", taken_count, mispredict_count); end
            end
        end
        drive(1'b0, 3'b000, 32'h0, 32'h0, 1'b0, 32'h0);
    endtask

    task automatic test_nobranch();
        do_reset();
        drive(1'b1, 3'b010, 32'd7, 32'd7, 1'b0, 32'h0000_0080);
        tick();
        total++; if (out_valid !== 1'b1 || out_taken !== 1'b0 || flush !== 1'b0) begin bad++; $display("FAIL bne_eq got v/t/f=%0b%0b%0b exp=100", out_valid, out_taken, flush); end
        drive(1'b1, 3'b000, 32'd7, 32'd8, 1'b1, 32'h0000_0080);
        tick();
        total++; if (out_valid !== 1'b0 || out_mispredict !== 1'b0) begin bad++; $display("FAIL op000 got v/m=%0b%0b exp=00", out_valid, out_mispredict); end
        drive(1'b1, 3'b111, 32'd7, 32'd8, 1'b1, 32'h0000_0080);
        tick();
        total++; if (out_valid !== 1'b0 || flush !== 1'b0) begin bad++; $display("FAIL op111 got v/f=%0b%0b exp=00", out_valid, flush); end
        drive(1'b0, 3'b010, 32'd7, 32'd8, 1'b0, 32'h0000_0080);
        tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL invalid got=%0b exp=0", out_valid); end
        total++; if (taken_count !== 16'd0 || mispredict_count !== 16'd0) begin bad++; $display("FAIL nobranch_counts got=%0d/%0d exp=0/0", taken_count, mispredict_count); end
    endtask

    task automatic test_stall_flush();
        do_reset();
        lookup_pc = 32'h0000_0144;
        drive(1'b1, 3'b110, 32'd0, 32'd0, 1'b0, 32'h0000_0144);
        tick();
        total++; if (flush !== 1'b1 || out_taken !== 1'b1) begin bad++; $display("FAIL blez_flush got f/t=%0b%0b exp=11", flush, out_taken); end
        stall = 1'b1;
        drive(1'b1, 3'b011, 32'd0, 32'd0, 1'b1, 32'h0000_0144);
        for (int i = 0; i < 3; i++) begin
            tick();
            total++; if (flush !== 1'b1 || out_valid !== 1'b1 || out_taken !== 1'b1) begin bad++; $display("FAIL stall_hold_%0d got f/v/t=%0b%0b%0b exp=111", i, flush, out_valid, out_taken); end
            total++; if (predict_taken !== 1'b1) begin bad++; $display("FAIL stall_bht_%0d got=%0b exp=1", i, predict_taken); end
        end
        total++; if (taken_count !== 16'd1 || mispredict_count !== 16'd1) begin bad++; $display("FAIL stall_counts got=%0d/%0d exp=1/1", taken_count, mispredict_count); end
        stall = 1'b0;
        drive(1'b0, 3'b000, 32'h0, 32'h0, 1'b0, 32'h0000_0144);
        tick();
        total++; if (flush !== 1'b0 || out_valid !== 1'b0) begin bad++; $display("FAIL unstall got f/v=%0b%0b exp=00", flush, out_valid); end
        total++; if (predict_taken !== 1'b1) begin bad++; $display("FAIL unstall_bht got=%0b exp=1", predict_taken); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        drive(1'b1, 3'b101, 32'hFFFF_FFFF, 32'h0, 1'b1, 32'h0000_0010);
        tick();
        total++; if (out_valid !== 1'b1 || out_taken !== 1'b1 || flush !== 1'b0) begin bad++; $display("FAIL b2b_0 got v/t/f=%0b%0b%0b exp=110", out_valid, out_taken, flush); end
        drive(1'b1, 3'b011, 32'h0000_0001, 32'h0, 1'b0, 32'h0000_0014);
        tick();
        total++; if (out_valid !== 1'b1 || out_taken !== 1'b1 || flush !== 1'b1) begin bad++; $display("FAIL b2b_1 got v/t/f=%0b%0b%0b exp=111", out_valid, out_taken, flush); end
        drive(1'b1, 3'b001, 32'd1, 32'd2, 1'b0, 32'h0000_0018);
        tick();
        total++; if (out_valid !== 1'b1 || out_taken !== 1'b0 || flush !== 1'b0) begin bad++; $display("FAIL b2b_2 got v/t/f=%0b%0b%0b exp=100", out_valid, out_taken, flush); end
        total++; if (taken_count !== 16'd2 || mispredict_count !== 16'd1) begin bad++; $display("FAIL b2b_counts got=%0d/%0d exp=2/1", taken_count, mispredict_count); end
        drive(1'b0, 3'b000, 32'h0, 32'h0, 1'b0, 32'h0);
    endtask

    task automatic test_saturation();
        logic [1:0] exp_small [5];
        exp_small[0] = 2'd1; exp_small[1] = 2'd2; exp_small[2] = 2'd3;
        exp_small[3] = 2'd3; exp_small[4] = 2'd3;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 3'b101, 32'hFFFF_FFFF, 32'h0, 1'b0, 32'h0000_0020);
            tick();
            total++; if (s_taken_count !== exp_small[i] || s_mispredict_count !== exp_small[i]) begin bad++; $display("FAIL sat_%0d got=%0d/%0d exp=%0d/%0d", i, s_taken_count, s_mispredict_count, exp_small[i], exp_small[i]); end
        end
        total++; if (taken_count !== 16'd5) begin bad++; $display("FAIL sat_wide got=%0d exp=5", taken_count); end
        reset = 1'b1;
        tick();
        total++; if (out_valid !== 1'b0 || flush !== 1'b0 || s_out_valid !== 1'b0) begin bad++; $display("FAIL midreset_out got v/f/sv=%0b%0b%0b exp=000", out_valid, flush, s_out_valid); end
        total++; if (taken_count !== 16'd0 || s_taken_count !== 2'd0 || s_mispredict_count !== 2'd0) begin bad++; $display("FAIL midreset_cnt got=%0d/%0d/%0d exp=0/0/0", taken_count, s_taken_count, s_mispredict_count); end
        reset = 1'b0;
        tick();
        total++; if (out_valid !== 1'b1 || taken_count !== 16'd1 || s_taken_count !== 2'd1) begin bad++; $display("FAIL post_reset got v=%0b cnt=%0d/%0d exp=1 1/1", out_valid, taken_count, s_taken_count); end
        drive(1'b0, 3'b000, 32'h0, 32'h0, 1'b0, 32'h0);
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        reset     = 1'b1;
        stall     = 1'b0;
        lookup_pc = 32'h0;
        drive(1'b0, 3'b000, 32'h0, 32'h0, 1'b0, 32'h0);
        test_reset();
        test_signed_bgez();
        test_conditions();
        test_bht_train();
        test_nobranch();
        test_stall_flush();
        test_back_to_back();
        test_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
